// File: rtl/vecmac_acc_pipe.sv
// N-lane W-bit dot-product MAC that accumulates over beat groups ended by in_last.
// Optional accumulator saturation with a sticky overflow flag: define VECMAC_SAT_EN.
module vecmac_acc_pipe #(
    parameter int LANES = 4,
    parameter int W     = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic                 in_signed,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    localparam int PW = 2*W+1;

    logic adv;
    logic accept;

    // A held, unconsumed result freezes the whole pipe so no beat is dropped.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;

    logic [PW-1:0] prod_c  [LANES];
    logic [PW-1:0] s1_prod [LANES];
    logic          s1_valid;
    logic          s1_last;

    // Low PW bits of the product are exact for both signed and unsigned operands.
    always_comb begin
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = '0;
        eb = '0;
        for (int k = 0; k < LANES; k++) begin
            ea = {{(W+1){in_signed & in_a[k*W+W-1]}}, in_a[k*W +: W]};
            eb = {{(W+1){in_signed & in_b[k*W+W-1]}}, in_b[k*W +: W]};
            prod_c[k] = ea * eb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod_c;
                s1_last <= in_last;
            end
        end
    end

    logic [ACC_W-1:0] lane_sum_c;
    logic [ACC_W-1:0] s2_sum;
    logic             s2_valid;
    logic             s2_last;

    always_comb begin
        lane_sum_c = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum_c = lane_sum_c + {{(ACC_W-PW){s1_prod[k][PW-1]}}, s1_prod[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= lane_sum_c;
                s2_last <= s1_last;
            end
        end
    end

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef VECMAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;
    logic           clamp;
    logic           acc_ovf;

    always_comb begin
        wide  = {acc[ACC_W-1], acc} + {s2_sum[ACC_W-1], s2_sum};
        clamp = wide[ACC_W] != wide[ACC_W-1];
        if (!clamp)
            sum_c = wide[ACC_W-1:0];
        else if (wide[ACC_W])
            sum_c = ACC_MIN;
        else
            sum_c = ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
            acc_ovf <= 1'b0;
        end else if (adv && s2_valid) begin
            if (s2_last) begin
                out_ovf <= acc_ovf | clamp;
                acc_ovf <= 1'b0;
            end else begin
                acc_ovf <= acc_ovf | clamp;
            end
        end
    end
`else
    assign sum_c   = acc + s2_sum;
    assign out_ovf = 1'b0;
`endif

    // The last beat clears the running state in the same cycle it publishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (adv) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_acc   <= sum_c;
                    out_count <= cnt_inc;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_vecmac_acc_pipe.sv
// Self-checking bench for vecmac_acc_pipe: directed cases plus a random stream vs. a group-level model.
module tb_vecmac_acc_pipe;

    localparam int LANES  = 4;
    localparam int W      = 8;
    localparam int ACC_W2 = 20;
    localparam int CNT_W2 = 2;
`ifdef VECMAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_acc;
    logic [15:0] out_count;

    logic              in_ready2, out_valid2, out_ovf2;
    logic [ACC_W2-1:0] out_acc2;
    logic [CNT_W2-1:0] out_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vecmac_acc_pipe #(.LANES(4), .W(8), .ACC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    vecmac_acc_pipe #(.LANES(4), .W(8), .ACC_W(ACC_W2), .CNT_W(CNT_W2)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2),
        .out_count(out_count2), .out_ovf(out_ovf2)
    );

    // Dot product of one beat, straight from the lane definition.
    function automatic longint beat_sum(logic [31:0] a, logic [31:0] b, bit sgn);
        longint s = 0;
        for (int k = 0; k < LANES; k++) begin
            logic [7:0] xa, xb;
            longint va, vb;
            xa = a[k*W +: W];
            xb = b[k*W +: W];
            va = sgn ? longint'($signed(xa)) : longint'(xa);
            vb = sgn ? longint'($signed(xb)) : longint'(xb);
            s += va * vb;
        end
        return s;
    endfunction

    // Accumulator step; wrap mode keeps the exact sum and is truncated on compare.
    function automatic longint acc_step(longint acc, longint x, int accw, bit sat, inout bit ovf);
        longint r, mx, mn;
        r  = acc + x;
        mx = (longint'(1) <<< (accw-1)) - 1;
        mn = -(longint'(1) <<< (accw-1));
        if (sat && r > mx) begin r = mx; ovf = 1'b1; end
        if (sat && r < mn) begin r = mn; ovf = 1'b1; end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit last);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_group(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                             input int beats, input bit bubble,
                             output bit got, output logic [31:0] acc, output logic [15:0] cnt,
                             output bit ovf, output int lat,
                             output logic [ACC_W2-1:0] acc2, output logic [CNT_W2-1:0] cnt2,
                             output bit ovf2);
        for (int i = 0; i < beats; i++) begin
            send_beat(a, b, sgn, i == beats-1);
            if (bubble && i < beats-1) @(negedge clk);
        end
        wait_out(lat);
        got = out_valid; acc = out_acc; cnt = out_count; ovf = out_ovf;
        acc2 = out_acc2; cnt2 = out_count2; ovf2 = out_ovf2;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_tests++; if (out_acc !== 32'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", out_acc); end
        n_tests++; if (out_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
        n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        bit got, ovf, ovf2; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2; logic [CNT_W2-1:0] cnt2;
        run_group(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || lat != 2) begin n_fail++; $display("FAIL single_latency got valid=%b lat=%0d want valid=1 lat=2", got, lat); end
        n_tests++; if (acc !== 32'd260100) begin n_fail++; $display("FAIL single_unsigned_acc got %0d want 260100", acc); end
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", cnt); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop got %b want 0", out_valid); end
        run_group(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc !== 32'd4) begin n_fail++; $display("FAIL single_signed_acc got %0d valid=%b want 4", acc, got); end
    endtask

    task automatic test_signed();
        bit got, ovf, ovf2; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2; logic [CNT_W2-1:0] cnt2;
        run_group(32'h8080_8080, 32'h8080_8080, 1'b1, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc !== 32'd65536) begin n_fail++; $display("FAIL signed_minmin got %0d want 65536", $signed(acc)); end
        run_group(32'h8080_8080, 32'h7F7F_7F7F, 1'b1, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || $signed(acc) != -65024) begin n_fail++; $display("FAIL signed_minmax got %0d want -65024", $signed(acc)); end
    endtask

    task automatic test_multi_beat();
        bit got, ovf, ovf2; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2; logic [CNT_W2-1:0] cnt2;
        run_group(32'h0102_0304, 32'h0102_0304, 1'b0, 3, 1'b1, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc !== 32'd90) begin n_fail++; $display("FAIL group3_acc got %0d want 90", acc); end
        n_tests++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL group3_count got %0d want 3", cnt); end
        run_group(32'h0, 32'h0, 1'b0, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc !== 32'd0 || cnt !== 16'd1) begin n_fail++; $display("FAIL zero_group got acc=%0d cnt=%0d want acc=0 cnt=1", acc, cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] qa[$];
        logic [31:0] ea, held;
        int idx = 0, got = 0, cyc = 0, bad_ready = 0, bad_hold = 0, bad_data = 0, blocked = 0;
        bit holding = 1'b0;
        do_reset();
        while (got < 5 && cyc < 200) begin
            out_ready = (cyc >= 10);
            if (idx < 5) begin
                in_valid = 1'b1; in_a = $urandom(); in_b = $urandom();
                in_signed = 1'($urandom_range(0, 1)); in_last = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                blocked++;
                if (in_ready !== 1'b0) bad_ready++;
                if (holding && out_acc !== held) bad_hold++;
                held = out_acc; holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (in_valid && in_ready) begin
                longint s;
                s = beat_sum(in_a, in_b, in_signed);
                qa.push_back(s[31:0]);
                idx++;
            end
            if (out_valid && out_ready) begin
                ea = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
                if (out_acc !== ea || out_count !== 16'd1) bad_data++;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (got != 5 || idx != 5 || qa.size() != 0) begin n_fail++; $display("FAIL bp_count got results=%0d sent=%0d left=%0d want 5/5/0", got, idx, qa.size()); end
        n_tests++; if (blocked == 0 || bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready blocked=%0d bad=%0d want >0/0", blocked, bad_ready); end
        n_tests++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_hold_stable got %0d changes want 0", bad_hold); end
        n_tests++; if (bad_data != 0) begin n_fail++; $display("FAIL bp_order got %0d bad results want 0", bad_data); end
    endtask

    task automatic test_reset_mid_group();
        bit got, ovf, ovf2; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2; logic [CNT_W2-1:0] cnt2;
        do_reset();
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_during got %b want 0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_after got %b want 0", out_valid); end
        run_group(32'h1, 32'h1, 1'b0, 1, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc !== 32'd1 || cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_group got acc=%0d cnt=%0d want acc=1 cnt=1", acc, cnt); end
    endtask

    task automatic test_narrow_acc();
        bit got, ovf, ovf2, movf; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2, e2; logic [CNT_W2-1:0] cnt2;
        longint m;
        do_reset();
        m = 0; movf = 1'b0;
        for (int i = 0; i < 3; i++) m = acc_step(m, beat_sum(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), ACC_W2, SAT, movf);
        e2 = m[ACC_W2-1:0];
        run_group(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || acc2 !== e2) begin n_fail++; $display("FAIL narrow_acc got %0d want %0d", acc2, e2); end
        n_tests++; if (ovf2 !== movf) begin n_fail++; $display("FAIL narrow_ovf got %b want %b", ovf2, movf); end
        n_tests++; if (acc !== 32'd780300 || ovf !== 1'b0) begin n_fail++; $display("FAIL wide_acc got %0d ovf=%b want 780300 ovf=0", acc, ovf); end
    endtask

    task automatic test_count_sat();
        bit got, ovf, ovf2; logic [31:0] acc; logic [15:0] cnt; int lat;
        logic [ACC_W2-1:0] acc2; logic [CNT_W2-1:0] cnt2;
        run_group(32'h0, 32'h0, 1'b0, 5, 1'b0, got, acc, cnt, ovf, lat, acc2, cnt2, ovf2);
        n_tests++; if (!got || cnt2 !== 2'd3) begin n_fail++; $display("FAIL count_sat got %0d want 3", cnt2); end
        n_tests++; if (cnt !== 16'd5) begin n_fail++; $display("FAIL count_5 got %0d want 5", cnt); end
    endtask

    task automatic test_random_stream();
        localparam int N = 10000;
        logic [31:0] qa[$];
        logic [15:0] qc[$];
        logic [31:0] ea;
        logic [15:0] ec;
        longint gacc = 0;
        int gcnt = 0, sent = 0, cyc = 0;
        bit dummy = 1'b0;
        do_reset();
        while ((sent < N || qa.size() > 0) && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1; in_a = $urandom(); in_b = $urandom();
                in_signed = 1'($urandom_range(0, 1));
                in_last = (sent == N-1) || ($urandom_range(0, 3) == 0);
            end else begin
                in_valid = 1'b0; in_a = $urandom(); in_b = $urandom();
            end
            #1;
            if (in_valid && in_ready) begin
                gacc = acc_step(gacc, beat_sum(in_a, in_b, in_signed), 32, SAT, dummy);
                gcnt++; sent++;
                if (in_last) begin
                    qa.push_back(gacc[31:0]); qc.push_back(gcnt[15:0]);
                    gacc = 0; gcnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra got acc=%0d want no result", out_acc);
                end else begin
                    ea = qa.pop_front(); ec = qc.pop_front();
                    if (out_acc !== ea || out_count !== ec || out_ovf !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stream_result got acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d ovf=0", out_acc, out_count, out_ovf, ea, ec);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (sent != N || qa.size() != 0) begin n_fail++; $display("FAIL stream_complete got sent=%0d pending=%0d want %0d/0", sent, qa.size(), N); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_signed();
        test_multi_beat();
        test_backpressure();
        test_reset_mid_group();
        test_narrow_acc();
        test_count_sat();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
